// File: rtl/raster_pkg.sv
// Shared types and defaults for the flat-shaded triangle rasteriser.
package raster_pkg;

    localparam int DEF_COORD_W  = 16;
    localparam int DEF_FRAC_W   = 8;
    localparam int DEF_SCREEN_W = 640;
    localparam int DEF_SCREEN_H = 480;
    localparam int DEF_COLOR_W  = 8;
    // Vertex storage is sized for the widest coordinate the block supports.
    localparam int MAX_COORD_W  = 32;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SCAN,
        FINISH
    } state_t;

    typedef struct packed {
        logic signed [MAX_COORD_W-1:0] x;
        logic signed [MAX_COORD_W-1:0] y;
    } vertex_t;

    function automatic int min3(input int a, input int b, input int c);
        int m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    function automatic int clamp(input int v, input int hi);
        return (v < 0) ? 0 : ((v > hi) ? hi : v);
    endfunction

endpackage

// File: rtl/edge_eval.sv
// One triangle edge: coefficients and start-pixel value at setup, then
// incremental stepping across the bounding box (no per-pixel multiply).
module edge_eval
    import raster_pkg::*;
#(
    parameter int COORD_W = DEF_COORD_W,
    parameter int FRAC_W  = DEF_FRAC_W,
    parameter int XW      = $clog2(DEF_SCREEN_W),
    parameter int YW      = $clog2(DEF_SCREEN_H),
    parameter int EW      = 2*COORD_W + 4
)(
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      load,
    input  logic                      step_x,
    input  logic                      step_row,
    input  logic signed [COORD_W-1:0] ax,
    input  logic signed [COORD_W-1:0] ay,
    input  logic signed [COORD_W-1:0] bx,
    input  logic signed [COORD_W-1:0] by,
    input  logic [XW-1:0]             sx,
    input  logic [YW-1:0]             sy,
    output logic signed [EW-1:0]      value
);
    localparam logic signed [EW-1:0] HALF = EW'(1) <<< (FRAC_W - 1);

    logic signed [EW-1:0] dx, dy, ox, oy, e0, cx, cy;
    logic signed [EW-1:0] cx_q, cy_q, row_q, cur_q;

    // E(p) = (b-a) x (p-a), sampled at the pixel centre of (sx,sy).
    always_comb begin
        dx = EW'(bx) - EW'(ax);
        dy = EW'(by) - EW'(ay);
        ox = (EW'(sx) <<< FRAC_W) + HALF - EW'(ax);
        oy = (EW'(sy) <<< FRAC_W) + HALF - EW'(ay);
        e0 = dx * oy - dy * ox;
        cx = -(dy <<< FRAC_W);
        cy = dx <<< FRAC_W;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cx_q  <= '0;
            cy_q  <= '0;
            row_q <= '0;
            cur_q <= '0;
        end else if (load) begin
            cx_q  <= cx;
            cy_q  <= cy;
            row_q <= e0;
            cur_q <= e0;
        end else if (step_row) begin
            row_q <= row_q + cy_q;
            cur_q <= row_q + cy_q;
        end else if (step_x) begin
            cur_q <= cur_q + cx_q;
        end
    end

    assign value = cur_q;

endmodule

// File: rtl/tri_raster.sv
// Flat-shaded triangle rasteriser: setup (area, winding, bbox), then a
// row-major scan testing one pixel per cycle against three edge functions.
module tri_raster
    import raster_pkg::*;
#(
    parameter int COORD_W  = DEF_COORD_W,
    parameter int FRAC_W   = DEF_FRAC_W,
    parameter int SCREEN_W = DEF_SCREEN_W,
    parameter int SCREEN_H = DEF_SCREEN_H,
    parameter int COLOR_W  = DEF_COLOR_W
)(
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        tri_valid,
    output logic                        tri_ready,
    input  logic signed [COORD_W-1:0]   v1x,
    input  logic signed [COORD_W-1:0]   v1y,
    input  logic signed [COORD_W-1:0]   v2x,
    input  logic signed [COORD_W-1:0]   v2y,
    input  logic signed [COORD_W-1:0]   v3x,
    input  logic signed [COORD_W-1:0]   v3y,
    input  logic [3*COLOR_W-1:0]        tri_rgb,
    input  logic                        cull_en,
    output logic                        frag_valid,
    input  logic                        frag_ready,
    output logic [$clog2(SCREEN_W)-1:0] frag_x,
    output logic [$clog2(SCREEN_H)-1:0] frag_y,
    output logic [3*COLOR_W-1:0]        frag_rgb,
    output logic                        busy,
    output logic                        done
);
    localparam int XW = $clog2(SCREEN_W);
    localparam int YW = $clog2(SCREEN_H);
    localparam int AW = 2*COORD_W + 2;
    localparam int EW = 2*COORD_W + 4;

    state_t               state, state_nx;
    vertex_t              v1_q, v2_q, v3_q;
    logic [3*COLOR_W-1:0] rgb_q;
    logic                 cull_q, setup_ph, scan_end_q;
    logic [XW-1:0]        xmin_q, xmax_q, px_q;
    logic [YW-1:0]        ymin_q, ymax_q, py_q;

    logic signed [AW-1:0] area;
    logic                 swap, reject;
    int                   bx_lo, bx_hi, by_lo, by_hi;

    always_comb begin
        area = (AW'(v2_q.x) - AW'(v1_q.x)) * (AW'(v3_q.y) - AW'(v1_q.y))
             - (AW'(v2_q.y) - AW'(v1_q.y)) * (AW'(v3_q.x) - AW'(v1_q.x));
        // Arithmetic shift of the fixed-point value gives floor().
        bx_lo  = min3(int'(v1_q.x), int'(v2_q.x), int'(v3_q.x)) >>> FRAC_W;
        bx_hi  = max3(int'(v1_q.x), int'(v2_q.x), int'(v3_q.x)) >>> FRAC_W;
        by_lo  = min3(int'(v1_q.y), int'(v2_q.y), int'(v3_q.y)) >>> FRAC_W;
        by_hi  = max3(int'(v1_q.y), int'(v2_q.y), int'(v3_q.y)) >>> FRAC_W;
        swap   = (area < 0) && !cull_q;
        reject = (area == 0) || ((area < 0) && cull_q)
               || (bx_hi < 0) || (by_hi < 0)
               || (bx_lo > SCREEN_W - 1) || (by_lo > SCREEN_H - 1);
    end

    logic signed [COORD_W-1:0] ex [3];
    logic signed [COORD_W-1:0] ey [3];
    logic signed [EW-1:0]      ev [3];
    logic                      edge_load, step_x, step_row;
    logic                      can_go, test, row_end, last, covered;

    assign ex[0] = COORD_W'(v1_q.x);
    assign ey[0] = COORD_W'(v1_q.y);
    assign ex[1] = COORD_W'(v2_q.x);
    assign ey[1] = COORD_W'(v2_q.y);
    assign ex[2] = COORD_W'(v3_q.x);
    assign ey[2] = COORD_W'(v3_q.y);

    assign can_go    = !frag_valid || frag_ready;
    assign test      = (state == SCAN) && !scan_end_q && can_go;
    assign row_end   = (px_q == xmax_q);
    assign last      = row_end && (py_q == ymax_q);
    assign edge_load = (state == SETUP) && setup_ph;
    assign step_x    = test && !row_end;
    assign step_row  = test && row_end && !last;
    assign covered   = (ev[0] >= 0) && (ev[1] >= 0) && (ev[2] >= 0);

    // Edges v1->v2, v2->v3, v3->v1; positive area means inside is >= 0.
    for (genvar i = 0; i < 3; i++) begin : g_edge
        edge_eval #(
            .COORD_W (COORD_W),
            .FRAC_W  (FRAC_W),
            .XW      (XW),
            .YW      (YW),
            .EW      (EW)
        ) u_edge (
            .clk      (clk),
            .reset_n  (reset_n),
            .load     (edge_load),
            .step_x   (step_x),
            .step_row (step_row),
            .ax       (ex[i]),
            .ay       (ey[i]),
            .bx       (ex[(i+1)%3]),
            .by       (ey[(i+1)%3]),
            .sx       (xmin_q),
            .sy       (ymin_q),
            .value    (ev[i])
        );
    end

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (tri_valid) state_nx = SETUP;
            SETUP:   if (!setup_ph) state_nx = reject ? FINISH : SETUP;
                     else           state_nx = SCAN;
            SCAN:    if (scan_end_q && can_go) state_nx = FINISH;
            FINISH:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign tri_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign done      = (state == FINISH);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            v1_q       <= '0;
            v2_q       <= '0;
            v3_q       <= '0;
            rgb_q      <= '0;
            cull_q     <= 1'b0;
            setup_ph   <= 1'b0;
            scan_end_q <= 1'b0;
            xmin_q     <= '0;
            xmax_q     <= '0;
            ymin_q     <= '0;
            ymax_q     <= '0;
            px_q       <= '0;
            py_q       <= '0;
            frag_valid <= 1'b0;
            frag_x     <= '0;
            frag_y     <= '0;
            frag_rgb   <= '0;
        end else begin
            case (state)
                IDLE: if (tri_valid) begin
                    v1_q     <= '{x: MAX_COORD_W'(v1x), y: MAX_COORD_W'(v1y)};
                    v2_q     <= '{x: MAX_COORD_W'(v2x), y: MAX_COORD_W'(v2y)};
                    v3_q     <= '{x: MAX_COORD_W'(v3x), y: MAX_COORD_W'(v3y)};
                    rgb_q    <= tri_rgb;
                    cull_q   <= cull_en;
                    setup_ph <= 1'b0;
                end
                SETUP: if (!setup_ph) begin
                    setup_ph <= 1'b1;
                    if (swap) begin
                        v2_q <= v3_q;
                        v3_q <= v2_q;
                    end
                    xmin_q <= XW'(clamp(bx_lo, SCREEN_W - 1));
                    xmax_q <= XW'(clamp(bx_hi, SCREEN_W - 1));
                    ymin_q <= YW'(clamp(by_lo, SCREEN_H - 1));
                    ymax_q <= YW'(clamp(by_hi, SCREEN_H - 1));
                end else begin
                    px_q       <= xmin_q;
                    py_q       <= ymin_q;
                    scan_end_q <= 1'b0;
                end
                SCAN: begin
                    if (frag_valid && frag_ready) frag_valid <= 1'b0;
                    if (test) begin
                        if (covered) begin
                            frag_valid <= 1'b1;
                            frag_x     <= px_q;
                            frag_y     <= py_q;
                            frag_rgb   <= rgb_q;
                        end
                        if (last) begin
                            scan_end_q <= 1'b1;
                        end else if (row_end) begin
                            px_q <= xmin_q;
                            py_q <= py_q + 1'b1;
                        end else begin
                            px_q <= px_q + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
